// File: rtl/axi_lite_mbox_pkg.sv
// Shared definitions for the multi-channel AXI-Lite mailbox.
// Contents:
// - Register offsets within a channel.
// - STATUS and IRQ_PEND bit positions.
// - The per-channel address stride.
// - AXI-Lite response codes.
// - Default AXI-Lite request/response payload structs.
package axi_lite_mbox_pkg;

  localparam int unsigned AxiAddrW   = 32;
  localparam int unsigned AxiDataW   = 32;
  localparam int unsigned ChanStride = 'h20;

  // Register index within a channel (offset[4:2])
  localparam logic [2:0] RegData    = 3'd0;
  localparam logic [2:0] RegStatus  = 3'd1;
  localparam logic [2:0] RegThresh  = 3'd2;
  localparam logic [2:0] RegIrqEn   = 3'd3;
  localparam logic [2:0] RegIrqPend = 3'd4;
  localparam logic [2:0] RegCtrl    = 3'd5;
  localparam logic [2:0] RegCount   = 3'd6;

  localparam int unsigned StatusEmpty = 0;
  localparam int unsigned StatusFull  = 1;
  localparam int unsigned StatusLevel = 8;

  localparam int unsigned PendLevel = 0;
  localparam int unsigned PendErr   = 1;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } resp_e;

  typedef struct packed {
    logic [AxiAddrW-1:0] addr;
  } ax_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0] data;
    logic [3:0]          strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_lite_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_lite_t;

  // Only STATUS is read-only; IRQ_PEND is W1C on its sticky bit.
  function automatic logic reg_is_ro(input logic [2:0] idx);
    return idx == RegStatus;
  endfunction

endpackage

// File: rtl/axi_lite_mbox_chan.sv
// One mailbox channel: a word FIFO plus its THRESH, IRQ_EN and IRQ_PEND
// registers, flush control and interrupt generation.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, pop        FIFO requests (ignored and flagged as an error when full/empty)
//   flush            empty the FIFO
//   wdata            write data for DATA, THRESH and IRQ_EN
//   thresh_we        THRESH load strobe
//   irq_en_we        IRQ_EN load strobe
//   pend_clr         clear the sticky error bit
//   head             word at the FIFO head
//   empty, full      FIFO state
//   level            number of words held
//   thresh, irq_en   register values
//   pend             {error, level > thresh}
//   irq              interrupt, level or edge mode
module axi_lite_mbox_chan
  import axi_lite_mbox_pkg::*;
#(
  parameter int unsigned Depth       = 8,
  parameter int unsigned LvlW        = $clog2(Depth + 1),
  parameter bit          IrqEdgeTrig = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     wdata,
  input  logic            thresh_we,
  input  logic            irq_en_we,
  input  logic            pend_clr,
  output logic [31:0]     head,
  output logic            empty,
  output logic            full,
  output logic [LvlW-1:0] level,
  output logic [LvlW-1:0] thresh,
  output logic [1:0]      irq_en,
  output logic [1:0]      pend,
  output logic            irq
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [31:0]     mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [LvlW-1:0] count;
  logic            err_q;
  logic            lvl_q;
  logic            do_push;
  logic            do_pop;
  logic            err_set;
  logic            irq_lvl;

  // Full/empty come from the registered count, so a same-cycle pop
  // never makes room for a push.
  assign empty   = (count == '0);
  assign full    = (count == LvlW'(Depth));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign err_set = (push & full) | (pop & empty);
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage: no reset, contents are invalidated by the count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and level; flush wins over a same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LvlW'(1);
        2'b01:   count <= count - LvlW'(1);
        default: count <= count;
      endcase
    end
  end

  // Config registers; a new error takes priority over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= '0;
      irq_en <= '0;
      err_q  <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      if (thresh_we) thresh <= wdata[LvlW-1:0];
      if (irq_en_we) irq_en <= wdata[1:0];
      if (err_set)       err_q <= 1'b1;
      else if (pend_clr) err_q <= 1'b0;
      lvl_q <= irq_lvl;
    end
  end

  assign pend[PendLevel] = (count > thresh);
  assign pend[PendErr]   = err_q;
  assign irq_lvl         = |(pend & irq_en);
  assign irq             = IrqEdgeTrig ? (irq_lvl & ~lvl_q) : irq_lvl;

endmodule

// File: rtl/axi_lite_mbox_array.sv
// Multi-channel AXI-Lite mailbox: NumChannels word FIFOs behind one slave port.
// Each channel occupies a 0x20-byte window starting at base_addr_i.
// Ports:
//   clk_i        clock
//   rst_ni       async active-low reset
//   base_addr_i  window base address
//   slv_req_i    AXI-Lite request
//   slv_resp_o   AXI-Lite response
//   irq_o        per-channel interrupt
module axi_lite_mbox_array #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned Depth       = 8,
  parameter bit          IrqEdgeTrig = 1'b0,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter type         req_lite_t  = axi_lite_mbox_pkg::req_lite_t,
  parameter type         resp_lite_t = axi_lite_mbox_pkg::resp_lite_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  req_lite_t              slv_req_i,
  output resp_lite_t             slv_resp_o,
  output logic [NumChannels-1:0] irq_o
);

  import axi_lite_mbox_pkg::*;

  localparam int unsigned LvlW   = $clog2(Depth + 1);
  localparam int unsigned ChIdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam logic [AddrWidth-1:0] WinSize = AddrWidth'(NumChannels * ChanStride);

  if (DataWidth != 32) begin : g_dw_check
    $fatal(1, "axi_lite_mbox_array: DataWidth must be 32");
  end
  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_depth_check
    $fatal(1, "axi_lite_mbox_array: Depth must be a power of two >= 2");
  end

  typedef enum logic {W_IDLE, W_BRESP} wstate_e;
  typedef enum logic {R_IDLE, R_RRESP} rstate_e;

  wstate_e w_state;
  rstate_e r_state;
  logic    w_rdy_q;
  logic    r_rdy_q;
  logic    b_valid_q;
  resp_e   b_resp_q;
  logic    r_valid_q;
  resp_e   r_resp_q;
  logic [31:0] r_data_q;

  logic w_accept;
  logic r_accept;

  logic [AddrWidth-1:0] aw_off;
  logic [AddrWidth-1:0] ar_off;
  logic [ChIdxW-1:0]    aw_ch;
  logic [ChIdxW-1:0]    ar_ch;
  logic [2:0]           aw_reg;
  logic [2:0]           ar_reg;
  logic                 aw_hit;
  logic                 ar_hit;

  resp_e       w_resp;
  resp_e       r_resp;
  logic [31:0] r_data;

  logic [NumChannels-1:0] push;
  logic [NumChannels-1:0] pop;
  logic [NumChannels-1:0] flush;
  logic [NumChannels-1:0] thresh_we;
  logic [NumChannels-1:0] irq_en_we;
  logic [NumChannels-1:0] pend_clr;
  logic [NumChannels-1:0] chan_empty;
  logic [NumChannels-1:0] chan_full;
  logic [31:0]            chan_head   [NumChannels];
  logic [LvlW-1:0]        chan_level  [NumChannels];
  logic [LvlW-1:0]        chan_thresh [NumChannels];
  logic [1:0]             chan_irq_en [NumChannels];
  logic [1:0]             chan_pend   [NumChannels];

  // Address decode; offsets below base wrap high and fall outside the window
  assign aw_off = AddrWidth'(slv_req_i.aw.addr) - base_addr_i;
  assign ar_off = AddrWidth'(slv_req_i.ar.addr) - base_addr_i;
  assign aw_ch  = aw_off[5 +: ChIdxW];
  assign ar_ch  = ar_off[5 +: ChIdxW];
  assign aw_reg = aw_off[4:2];
  assign ar_reg = ar_off[4:2];
  assign aw_hit = (aw_off < WinSize) && (aw_reg < RegCount);
  assign ar_hit = (ar_off < WinSize) && (ar_reg < RegCount);

  assign w_accept = w_rdy_q & slv_req_i.aw_valid & slv_req_i.w_valid;
  assign r_accept = r_rdy_q & slv_req_i.ar_valid;

  // Write decode: response code and per-channel strobes for the accept cycle
  always_comb begin
    w_resp    = RespOkay;
    push      = '0;
    flush     = '0;
    thresh_we = '0;
    irq_en_we = '0;
    pend_clr  = '0;
    if (!aw_hit) begin
      w_resp = RespDecErr;
    end else if (slv_req_i.w.strb != 4'hF) begin
      w_resp = RespSlvErr;
    end else if (reg_is_ro(aw_reg)) begin
      w_resp = RespSlvErr;
    end else begin
      case (aw_reg)
        RegData: begin
          if (chan_full[aw_ch]) w_resp = RespSlvErr;
          push[aw_ch] = w_accept;
        end
        RegThresh:  thresh_we[aw_ch] = w_accept;
        RegIrqEn:   irq_en_we[aw_ch] = w_accept;
        RegIrqPend: pend_clr[aw_ch]  = w_accept & slv_req_i.w.data[PendErr];
        RegCtrl:    flush[aw_ch]     = w_accept & slv_req_i.w.data[0];
        default:    w_resp = RespDecErr;
      endcase
    end
  end

  // Read decode: response code, read data and pop strobe for the accept cycle
  always_comb begin
    r_resp = RespOkay;
    r_data = '0;
    pop    = '0;
    if (!ar_hit) begin
      r_resp = RespDecErr;
    end else begin
      case (ar_reg)
        RegData: begin
          if (chan_empty[ar_ch]) r_resp = RespSlvErr;
          else                   r_data = chan_head[ar_ch];
          pop[ar_ch] = r_accept;
        end
        RegStatus: begin
          r_data[StatusLevel +: LvlW] = chan_level[ar_ch];
          r_data[StatusFull]          = chan_full[ar_ch];
          r_data[StatusEmpty]         = chan_empty[ar_ch];
        end
        RegThresh:  r_data = 32'(chan_thresh[ar_ch]);
        RegIrqEn:   r_data = 32'(chan_irq_en[ar_ch]);
        RegIrqPend: r_data = 32'(chan_pend[ar_ch]);
        RegCtrl:    r_data = '0;
        default:    r_resp = RespDecErr;
      endcase
    end
  end

  // Write handshake FSM: ready only while idle, one B outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state   <= W_IDLE;
      w_rdy_q   <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
    end else begin
      case (w_state)
        W_IDLE: begin
          w_rdy_q <= 1'b1;
          if (w_accept) begin
            w_state   <= W_BRESP;
            w_rdy_q   <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= w_resp;
          end
        end
        W_BRESP: begin
          if (slv_req_i.b_ready) begin
            w_state   <= W_IDLE;
            w_rdy_q   <= 1'b1;
            b_valid_q <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read handshake FSM: data captured at AR acceptance, held until rready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= R_IDLE;
      r_rdy_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          r_rdy_q <= 1'b1;
          if (r_accept) begin
            r_state   <= R_RRESP;
            r_rdy_q   <= 1'b0;
            r_valid_q <= 1'b1;
            r_resp_q  <= r_resp;
            r_data_q  <= r_data;
          end
        end
        R_RRESP: begin
          if (slv_req_i.r_ready) begin
            r_state   <= R_IDLE;
            r_rdy_q   <= 1'b1;
            r_valid_q <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_rdy_q;
    slv_resp_o.w_ready  = w_rdy_q;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.ar_ready = r_rdy_q;
    slv_resp_o.r_valid  = r_valid_q;
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    axi_lite_mbox_chan #(
      .Depth       (Depth),
      .LvlW        (LvlW),
      .IrqEdgeTrig (IrqEdgeTrig)
    ) u_chan (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .push      (push[c]),
      .pop       (pop[c]),
      .flush     (flush[c]),
      .wdata     (slv_req_i.w.data),
      .thresh_we (thresh_we[c]),
      .irq_en_we (irq_en_we[c]),
      .pend_clr  (pend_clr[c]),
      .head      (chan_head[c]),
      .empty     (chan_empty[c]),
      .full      (chan_full[c]),
      .level     (chan_level[c]),
      .thresh    (chan_thresh[c]),
      .irq_en    (chan_irq_en[c]),
      .pend      (chan_pend[c]),
      .irq       (irq_o[c])
    );
  end

endmodule
